// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer: function codes,
// FSM state encoding and the default operand width.
package muldiv_sequencer_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;

  localparam logic [3:0] FUNCT_MUL = 4'b0001;
  localparam logic [3:0] FUNCT_DIV = 4'b0010;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StDone = 2'b10
  } state_e;

  function automatic logic is_muldiv(logic [3:0] funct);
    return (funct == FUNCT_MUL) || (funct == FUNCT_DIV);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage request/response bundle between the pipeline and the mul/div sequencer.
interface muldiv_sequencer_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             start;
  logic [3:0]       functCode;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] resultLo;
  logic [WIDTH-1:0] resultHi;
  logic             divByZero;

  modport master (
    output start, functCode, opA, opB, flush,
    input  stall, busy, done, resultLo, resultHi, divByZero
  );

  modport slave (
    input  start, functCode, opA, opB, flush,
    output stall, busy, done, resultLo, resultHi, divByZero
  );

endinterface

// File: rtl/muldiv_step.sv
// One unsigned iteration: shift-add multiply (acc = {hi, multiplier}) or
// restoring divide (acc = {remainder, dividend/quotient}).
module muldiv_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               is_div,
  input  logic [WIDTH-1:0]   mag,
  input  logic [2*WIDTH-1:0] acc_in,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    acc_out = acc_in;
    sum     = '0;
    shifted = '0;
    diff    = '0;
    if (is_div) begin
      shifted = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
      diff    = shifted - {1'b0, mag};
      // Borrow out of the top bit means the trial subtraction went negative: restore.
      if (!diff[WIDTH]) begin
        acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
      end else begin
        acc_out = {shifted[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, mag} : '0);
      acc_out = {sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed MUL/DIV for the EX stage: stalls the pipeline while iterating,
// returns low result (product low / quotient) and high result (product high / remainder).
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned CNT_W = 5
) (
  input logic               clk,
  input logic               rst,
  muldiv_sequencer_if.slave bus
);

  localparam int unsigned W2 = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic             dbz_q, dbz_d;

  logic             go;
  logic             launch_div;
  logic             sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [W2-1:0]    acc_step;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign sa         = bus.opA[WIDTH-1];
  assign sb         = bus.opB[WIDTH-1];
  // -2^(WIDTH-1) maps onto itself, which is the correct unsigned magnitude.
  assign abs_a      = sa ? -bus.opA : bus.opA;
  assign abs_b      = sb ? -bus.opB : bus.opB;
  assign go         = bus.start & is_muldiv(bus.functCode) & (state_q == StIdle);
  assign launch_div = (bus.functCode == FUNCT_DIV);

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div  (is_div_q),
    .mag     (mag_q),
    .acc_in  (acc_q),
    .acc_out (acc_step)
  );

  assign prod_fix = (sign_a_q ^ sign_b_q) ? -acc_step : acc_step;
  assign quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
  assign rem_fix  = sign_a_q ? -acc_step[W2-1:WIDTH] : acc_step[W2-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    mag_d    = mag_q;
    acc_d    = acc_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    dbz_d    = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          is_div_d = launch_div;
          sign_a_d = sa;
          sign_b_d = sb;
          mag_d    = launch_div ? abs_b : abs_a;
          acc_d    = {{WIDTH{1'b0}}, (launch_div ? abs_a : abs_b)};
          cnt_d    = CNT_W'(WIDTH);
          if (launch_div && (bus.opB == '0)) begin
            res_lo_d = '1;
            res_hi_d = bus.opA;
            dbz_d    = 1'b1;
            state_d  = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d  = StDone;
            dbz_d    = 1'b0;
            res_lo_d = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
            res_hi_d = is_div_q ? rem_fix : prod_fix[W2-1:WIDTH];
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mag_q    <= '0;
      acc_q    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      mag_q    <= mag_d;
      acc_q    <= acc_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.stall     = go | (state_q == StCalc);
  assign bus.busy      = (state_q == StCalc);
  assign bus.done      = (state_q == StDone);
  assign bus.resultLo  = res_lo_q;
  assign bus.resultHi  = res_hi_q;
  assign bus.divByZero = dbz_q & (state_q == StDone);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: a vector table of signed MUL/DIV cases plus
// hand-written sequences for flush, ignored starts, async reset and back-to-back ops.
module tb_muldiv_sequencer;

  localparam logic [3:0] F_MUL = 4'b0001;
  localparam logic [3:0] F_DIV = 4'b0010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  muldiv_sequencer_if #(.WIDTH(16)) bus ();

  muldiv_sequencer #(
    .WIDTH (16),
    .CNT_W (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [3:0]  funct;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.functCode = f;
    bus.opA       = a;
    bus.opB       = b;
  endtask

  // Waits for done after a launch; returns the number of edges from launch edge to done.
  task automatic wait_done(output int lat);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] f, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] lo, input logic [15:0] hi,
                        input logic dbz, input int exp_lat);
    int lat;
    launch(f, a, b);
    #1;
    chk({tag, "_stall_launch"}, bus.stall, 1'b1);
    wait_done(lat);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_stall_in_done"}, bus.stall, 1'b0);
    chk({tag, "_lo"}, bus.resultLo, lo);
    chk({tag, "_hi"}, bus.resultHi, hi);
    chk({tag, "_dbz"}, bus.divByZero, dbz);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, bus.done, 1'b0);
    chk({tag, "_dbz_clear"}, bus.divByZero, 1'b0);
    chk({tag, "_lo_held"}, bus.resultLo, lo);
  endtask

  task automatic no_done_for(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_no_done"}, bus.done, 1'b0);
    end
  endtask

  initial begin
    int lat;
    bus.start     = 1'b0;
    bus.functCode = 4'b0000;
    bus.opA       = '0;
    bus.opB       = '0;
    bus.flush     = 1'b0;

    vecs[0]  = '{F_MUL, 16'h0007, 16'hFFFD, 16'hFFEB, 16'hFFFF, 1'b0, 17};
    vecs[1]  = '{F_DIV, 16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 17};
    vecs[2]  = '{F_DIV, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 17};
    vecs[3]  = '{F_DIV, 16'h0005, 16'h0000, 16'hFFFF, 16'h0005, 1'b1, 1};
    vecs[4]  = '{F_MUL, 16'h00FF, 16'h0101, 16'hFFFF, 16'h0000, 1'b0, 17};
    vecs[5]  = '{F_MUL, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 1'b0, 17};
    vecs[6]  = '{F_DIV, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 17};
    vecs[7]  = '{F_DIV, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 17};
    vecs[8]  = '{F_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 17};
    vecs[9]  = '{F_DIV, 16'h7FFF, 16'h0001, 16'h7FFF, 16'h0000, 1'b0, 17};
    vecs[10] = '{F_MUL, 16'h7FFF, 16'h7FFF, 16'h0001, 16'h3FFF, 1'b0, 17};

    // Reset state
    #2;
    chk("rst_stall", bus.stall, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_lo", bus.resultLo, 16'h0000);
    chk("rst_hi", bus.resultHi, 16'h0000);
    chk("rst_dbz", bus.divByZero, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("v%0d", i), vecs[i].funct, vecs[i].a, vecs[i].b, vecs[i].lo,
             vecs[i].hi, vecs[i].dbz, vecs[i].lat);
    end

    // Unsupported functCode: start ignored
    launch(4'b1111, 16'h0003, 16'h0004);
    #1;
    chk("badf_stall", bus.stall, 1'b0);
    chk("badf_busy", bus.busy, 1'b0);
    no_done_for("badf", 3);
    chk("badf_busy_after", bus.busy, 1'b0);
    bus.start = 1'b0;

    // Flush 5 cycles into CALC: back to IDLE, no done, results unchanged (last was v10)
    launch(F_MUL, 16'h00FF, 16'h0101);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("flush_busy_calc", bus.busy, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush_busy", bus.busy, 1'b0);
    chk("flush_stall", bus.stall, 1'b0);
    chk("flush_done", bus.done, 1'b0);
    no_done_for("flush", 20);
    chk("flush_lo_kept", bus.resultLo, 16'h0001);
    chk("flush_hi_kept", bus.resultHi, 16'h3FFF);
    run_op("refresh", F_MUL, 16'h00FF, 16'h0101, 16'hFFFF, 16'h0000, 1'b0, 17);

    // New MUL request while busy is ignored
    launch(F_MUL, 16'h0007, 16'hFFFD);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.opA   = 16'h0002;
    bus.opB   = 16'h0002;
    lat = 4;
    while (!bus.done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start = 1'b0;
    chk("busy_start_latency", lat, 17);
    chk("busy_start_lo", bus.resultLo, 16'hFFEB);
    chk("busy_start_hi", bus.resultHi, 16'hFFFF);
    @(posedge clk);
    #1;

    // Async reset mid-CALC
    launch(F_DIV, 16'hFF9C, 16'h0007);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_stall", bus.stall, 1'b0);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_done", bus.done, 1'b0);
    chk("arst_lo", bus.resultLo, 16'h0000);
    chk("arst_hi", bus.resultHi, 16'h0000);
    chk("arst_dbz", bus.divByZero, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    no_done_for("arst", 20);

    // Back-to-back MUL then DIV
    run_op("b2b_mul", F_MUL, 16'h0007, 16'hFFFD, 16'hFFEB, 16'hFFFF, 1'b0, 17);
    run_op("b2b_div", F_DIV, 16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
